// File: rtl/sdcm_pkg.sv
// sdcm_pkg: shared constants for the SD-card SPI port.
//   - register addresses (DATA / CTRL-STATUS)
//   - bit positions inside the status byte
//   - idle levels of the SPI pins
//   - helper that packs the status byte
package sdcm_pkg;

  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;

  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_CS_BIT   = 1;

  localparam logic SPI_SCLK_IDLE = 1'b0;
  localparam logic SPI_MOSI_IDLE = 1'b1;
  localparam logic SPI_CS_N_IDLE = 1'b1;

  // Status byte: all bits zero except busy and cs_assert.
  function automatic logic [7:0] make_status(input logic cs_assert, input logic busy);
    logic [7:0] s;
    s = 8'h00;
    s[STATUS_BUSY_BIT] = busy;
    s[STATUS_CS_BIT]   = cs_assert;
    return s;
  endfunction

endpackage

// File: rtl/sdcm_spi_shifter.sv
// sdcm_spi_shifter: SPI mode-0 byte engine (MSB first, sclk idle low).
// Macro SDCM_LOOPBACK_EN: when defined, the receive shifter samples the
// internal mosi line instead of spi_miso_i.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   start_i         begin a transfer of tx_data_i (ignored while busy)
//   tx_data_i [7:0] byte to transmit
//   spi_miso_i      serial data in
//   busy_o          transfer in progress
//   rx_data_o [7:0] last completed received byte
//   spi_sclk_o      SPI clock
//   spi_mosi_o      SPI data out
module sdcm_spi_shifter
  import sdcm_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic [7:0] tx_data_i,
  input  logic       spi_miso_i,
  output logic       busy_o,
  output logic [7:0] rx_data_o,
  output logic       spi_sclk_o,
  output logic       spi_mosi_o
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic       busy_q, busy_d;
  logic [7:0] div_q, div_d;
  logic [3:0] half_q, half_d;     // half-period index 0..15 within the byte
  logic       sclk_q, sclk_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_q, rx_d;
  logic       sample_bit;

  // mosi shows the current MSB of the TX shifter only while a byte is moving.
  assign spi_mosi_o = busy_q ? tx_q[7] : SPI_MOSI_IDLE;
  assign spi_sclk_o = sclk_q;
  assign busy_o     = busy_q;
  assign rx_data_o  = rx_q;

`ifdef SDCM_LOOPBACK_EN
  assign sample_bit = spi_mosi_o;
`else
  assign sample_bit = spi_miso_i;
`endif

  always_comb begin
    busy_d     = busy_q;
    div_d      = div_q;
    half_d     = half_q;
    sclk_d     = sclk_q;
    tx_d       = tx_q;
    rx_shift_d = rx_shift_q;
    rx_d       = rx_q;
    if (busy_q) begin
      if (div_q == DIV_LAST) begin
        div_d  = 8'd0;
        half_d = half_q + 4'd1;
        if (!sclk_q) begin
          // Low half done: rise sclk and capture the incoming bit.
          sclk_d     = 1'b1;
          rx_shift_d = {rx_shift_q[6:0], sample_bit};
        end else begin
          // High half done: fall sclk and present the next bit.
          sclk_d = 1'b0;
          tx_d   = {tx_q[6:0], 1'b1};
          if (half_q == 4'd15) begin
            busy_d = 1'b0;
            rx_d   = rx_shift_q;
          end
        end
      end else begin
        div_d = div_q + 8'd1;
      end
    end else if (start_i) begin
      busy_d = 1'b1;
      tx_d   = tx_data_i;
      div_d  = 8'd0;
      half_d = 4'd0;
      sclk_d = SPI_SCLK_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q     <= 1'b0;
      div_q      <= 8'd0;
      half_q     <= 4'd0;
      sclk_q     <= SPI_SCLK_IDLE;
      tx_q       <= 8'hFF;
      rx_shift_q <= 8'h00;
      rx_q       <= 8'h00;
    end else begin
      busy_q     <= busy_d;
      div_q      <= div_d;
      half_q     <= half_d;
      sclk_q     <= sclk_d;
      tx_q       <= tx_d;
      rx_shift_q <= rx_shift_d;
      rx_q       <= rx_d;
    end
  end

endmodule

// File: rtl/port_sdcm.sv
// port_sdcm: two-register CPU port to an SD card over SPI.
// Macro SDCM_LOOPBACK_EN (see sdcm_spi_shifter) loops mosi back into RX.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   enable            port select; gates reads and writes
//   addr              0 = DATA, 1 = CTRL/STATUS
//   w_strobe          write strobe
//   din [7:0]         write data
//   dout [7:0]        read data (combinational)
//   spi_sclk, spi_mosi, spi_miso, spi_cs_n   SD-card SPI pins
module port_sdcm
  import sdcm_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       addr,
  input  logic       w_strobe,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_cs_n
);

  logic       cs_q, cs_d;
  logic       busy;
  logic [7:0] rx_data;
  logic       wr_en;
  logic       data_start;

  assign wr_en      = enable && w_strobe;
  // Uses the registered busy, so a write on the cycle busy falls is dropped.
  assign data_start = wr_en && (addr == ADDR_DATA) && !busy;

  always_comb begin
    cs_d = cs_q;
    if (wr_en && (addr == ADDR_CTRL)) cs_d = din[0];
  end

  always_ff @(posedge clk) begin
    if (reset) cs_q <= 1'b0;
    else       cs_q <= cs_d;
  end

  assign spi_cs_n = ~cs_q;

  always_comb begin
    dout = 8'h00;
    if (enable) dout = (addr == ADDR_CTRL) ? make_status(cs_q, busy) : rx_data;
  end

  sdcm_spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk        (clk),
    .reset      (reset),
    .start_i    (data_start),
    .tx_data_i  (din),
    .spi_miso_i (spi_miso),
    .busy_o     (busy),
    .rx_data_o  (rx_data),
    .spi_sclk_o (spi_sclk),
    .spi_mosi_o (spi_mosi)
  );

endmodule

// File: tb/tb_port_sdcm.sv
module tb_port_sdcm;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       addr;
  logic       w_strobe;
  logic [7:0] din;
  logic [7:0] dout;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_cs_n;

  int n_total = 0;
  int n_pass  = 0;

  bit mosi_q[$];       // expected mosi bits, one per rising sclk
  bit sb_ignore = 1'b0;

  port_sdcm #(.CLK_DIV(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .addr     (addr),
    .w_strobe (w_strobe),
    .din      (din),
    .dout     (dout),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_cs_n (spi_cs_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
      $display("ok   %s: got 0x%0h", name, act);
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_rx(input logic [7:0] tx, input logic miso);
`ifdef SDCM_LOOPBACK_EN
    return tx;
`else
    return {8{miso}};
`endif
  endfunction

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) mosi_q.push_back(b[i]);
  endtask

  // Monitor: every rising sclk pops one expected mosi bit.
  initial begin
    forever begin
      @(posedge spi_sclk);
      #1;
      if (!sb_ignore) begin
        if (mosi_q.size() == 0) begin
          check("unexpected_sclk_rise", 1, 0);
        end else begin
          check("mosi_bit", int'(spi_mosi), int'(mosi_q.pop_front()));
        end
      end
    end
  end

  // One write cycle; returns at the negedge after the capturing edge with addr=CTRL.
  task automatic write_reg(input logic a, input logic [7:0] d);
    @(negedge clk);
    enable = 1'b1; addr = a; din = d; w_strobe = 1'b1;
    @(negedge clk);
    w_strobe = 1'b0; addr = 1'b1;
  endtask

  // Counts cycles with busy=1, reading status each negedge.
  task automatic wait_idle(output int n);
    n = 0;
    enable = 1'b1; addr = 1'b1;
    forever begin
      #1;
      if (!dout[0] || n >= 1000) break;
      n++;
      @(negedge clk);
    end
    if (n >= 1000) check("busy_timeout", n, 0);
  endtask

  task automatic finish_xfer(input string tag, input int exp_cycles,
                             input logic [7:0] exp_status, input logic [7:0] exp_rxv);
    int n;
    wait_idle(n);
    check({tag, "_busy_cycles"}, n, exp_cycles);
    check({tag, "_status"}, int'(dout), int'(exp_status));
    addr = 1'b0; #1;
    check({tag, "_rx"}, int'(dout), int'(exp_rxv));
    check({tag, "_bits_left"}, mosi_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; addr = 1'b0; w_strobe = 1'b0; din = 8'h00; spi_miso = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    enable = 1'b1; addr = 1'b0; #1;
    check("reset_dout_data", int'(dout), 8'h00);
    addr = 1'b1; #1;
    check("reset_dout_ctrl", int'(dout), 8'h00);
    check("reset_cs_n", int'(spi_cs_n), 1);
    check("reset_sclk", int'(spi_sclk), 0);
    check("reset_mosi", int'(spi_mosi), 1);

    // CS assert, then 0xA5 with miso high.
    write_reg(1'b1, 8'h01);
    #1; check("cs_n_asserted", int'(spi_cs_n), 0);
    check("status_cs_only", int'(dout), 8'h02);
    push_byte(8'hA5);
    write_reg(1'b0, 8'hA5);
    finish_xfer("a5", 32, 8'h02, exp_rx(8'hA5, 1'b1));
    #1; check("idle_mosi", int'(spi_mosi), 1);

    // Held strobe while busy: only the first 0x01 goes out.
    spi_miso = 1'b0;
    push_byte(8'h01);
    @(negedge clk);
    enable = 1'b1; addr = 1'b0; w_strobe = 1'b1; din = 8'h01;
    @(negedge clk); din = 8'h01;
    @(negedge clk); din = 8'h02;
    @(negedge clk); din = 8'h03;
    @(negedge clk); din = 8'h04;
    @(negedge clk); w_strobe = 1'b0; addr = 1'b1;
    finish_xfer("busywr", 28, 8'h02, exp_rx(8'h01, 1'b0));

    // Enable gating.
    spi_miso = 1'b1;
    @(negedge clk);
    enable = 1'b0; addr = 1'b0; w_strobe = 1'b1; din = 8'h02;
    #1; check("disabled_dout", int'(dout), 8'h00);
    @(negedge clk);
    w_strobe = 1'b0; enable = 1'b1; addr = 1'b1; #1;
    check("disabled_no_start", int'(dout), 8'h02);
    push_byte(8'h02);
    write_reg(1'b0, 8'h02);
    finish_xfer("en", 32, 8'h02, exp_rx(8'h02, 1'b1));

    // Reset abort around cycle 10 of a transfer.
    sb_ignore = 1'b1;
    write_reg(1'b0, 8'hFF);
    repeat (8) @(negedge clk);
    #1; check("abort_busy_before", int'(dout[0]), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; #1;
    check("abort_status", int'(dout), 8'h00);
    check("abort_sclk", int'(spi_sclk), 0);
    check("abort_mosi", int'(spi_mosi), 1);
    check("abort_cs_n", int'(spi_cs_n), 1);
    repeat (3) @(negedge clk);
    sb_ignore = 1'b0;
    spi_miso = 1'b0;
    push_byte(8'h04);
    write_reg(1'b0, 8'h04);
    finish_xfer("post_abort", 32, 8'h00, exp_rx(8'h04, 1'b0));

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
